// File: rtl/xalu_md_unit_if.sv
// xalu_md_unit_if: issue/result bundle between the execute stage and the multiply/divide unit
interface xalu_md_unit_if;
  logic start;
  logic [2:0] xop;
  logic [31:0] xa;
  logic [31:0] xb;
  logic rd_hi;
  logic busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] xalu_out;
  modport master(output start, xop, xa, xb, rd_hi, input busy, hi, lo, xalu_out);
  modport slave(input start, xop, xa, xb, rd_hi, output busy, hi, lo, xalu_out);
endinterface

// File: rtl/xalu_md_unit.sv
// xalu_md_unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO and MFHI/MFLO read port
module xalu_md_unit #(
  parameter int MULT_CYCLES = 5
) (
  input logic clk,
  input logic reset,
  xalu_md_unit_if.slave bus
);
  localparam int CW = $clog2(MULT_CYCLES > 32 ? MULT_CYCLES : 32);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [63:0] prod;
  logic [31:0] dvd, dvs, rem, hi, lo;
  logic neg_q, neg_r, busy;
  logic is_signed, sa, sb;
  logic [63:0] ea, eb, prod_in;
  logic [31:0] abs_a, abs_b, q_nx, r_nx;
  logic [32:0] rem_sh, diff;
  // Operand conditioning at issue and one restoring-division step; dvd doubles as the quotient shifter
  always_comb begin
    is_signed = bus.xop == 3'd1 || bus.xop == 3'd3;
    sa = is_signed & bus.xa[31];
    sb = is_signed & bus.xb[31];
    ea = {{32{sa}}, bus.xa};
    eb = {{32{sb}}, bus.xb};
    prod_in = ea * eb;
    abs_a = sa ? -bus.xa : bus.xa;
    abs_b = sb ? -bus.xb : bus.xb;
    rem_sh = {rem, dvd[31]};
    diff = rem_sh - {1'b0, dvs};
    q_nx = {dvd[30:0], ~diff[32]};
    r_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
  end
  // Control FSM: issue only from IDLE, HI/LO written solely on MTHI/MTLO or the commit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      prod <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.xop == 3'd1 || bus.xop == 3'd2) begin
            prod <= prod_in;
            cnt <= CW'(MULT_CYCLES - 1);
            state <= MUL;
            busy <= 1'b1;
          end else if (bus.xop == 3'd3 || bus.xop == 3'd4) begin
            dvd <= abs_a;
            dvs <= abs_b;
            rem <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt <= CW'(31);
            state <= DIV;
            busy <= 1'b1;
          end else if (bus.xop == 3'd5) begin
            hi <= bus.xa;
          end else if (bus.xop == 3'd6) begin
            lo <= bus.xa;
          end
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt - 1'b1;
          dvd <= q_nx;
          rem <= r_nx;
          if (cnt == '0) begin
            lo <= neg_q ? -q_nx : q_nx;
            hi <= neg_r ? -r_nx : r_nx;
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
  assign bus.busy = busy;
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.xalu_out = bus.rd_hi ? hi : lo;
endmodule
